// File: rtl/scie_pkg.sv
// rtl/scie_pkg.sv - shared constants and FSM state type for the SCIE FIR sequencer
package scie_pkg;

  localparam int XLEN_DEF = 32;
  localparam int TAPS_DEF = 5;

  localparam logic [31:0] INSN_LOAD_COEF = 32'h0000_000B;
  localparam logic [31:0] INSN_PUSH      = 32'h0000_002B;
  localparam logic [31:0] INSN_READ      = 32'h0000_005B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PUSH,
    S_GAP,
    S_READ,
    S_CAPT
  } seq_state_t;

endpackage

// File: rtl/scie_fir_sequencer.sv
// rtl/scie_fir_sequencer.sv - stream-to-instruction issue stage for the SCIE FIR unit
// Optional counters perf_samples/perf_stalls are built when SCIE_SEQ_PERF_EN is defined.
module scie_fir_sequencer
  import scie_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int TAPS = TAPS_DEF,
  localparam int IDXW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [IDXW-1:0] cfg_index,
  input  logic [XLEN-1:0] cfg_coef,
  output logic            cfg_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            scie_valid,
  output logic [31:0]     scie_insn,
  output logic [XLEN-1:0] scie_rs1,
  output logic [XLEN-1:0] scie_rs2,
  input  logic [XLEN-1:0] scie_rd,
  output logic            busy
`ifdef SCIE_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_samples,
  output logic [31:0]     perf_stalls
`endif
);

  localparam logic [IDXW:0] TAPS_W = TAPS[IDXW:0];

  seq_state_t      state, state_nx;
  logic            cfg_fire, cfg_bad, in_fire;
  logic            valid_nx;
  logic [31:0]     insn_nx;
  logic [XLEN-1:0] rs1_nx, rs2_nx;

  assign cfg_ready = (state == S_IDLE);
  assign in_ready  = (state == S_IDLE) && !cfg_valid && !out_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign cfg_bad   = {1'b0, cfg_index} >= TAPS_W;

  always_comb begin
    state_nx = state;
    valid_nx = 1'b0;
    insn_nx  = '0;
    rs1_nx   = '0;
    rs2_nx   = '0;
    case (state)
      S_IDLE: begin
        if (cfg_fire) begin
          if (!cfg_bad) state_nx = S_LOAD;
        end else if (in_fire) begin
          state_nx = S_PUSH;
        end
      end
      S_LOAD:  state_nx = S_IDLE;
      S_PUSH:  state_nx = S_GAP;
      S_GAP:   state_nx = S_READ;
      S_READ:  state_nx = S_CAPT;
      S_CAPT:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Instruction fields are registered from the next state, so the operand
    // registers double as the coefficient/sample latches.
    case (state_nx)
      S_LOAD: begin
        valid_nx = 1'b1;
        insn_nx  = INSN_LOAD_COEF;
        rs1_nx   = cfg_coef;
        rs2_nx   = {{(XLEN-IDXW){1'b0}}, cfg_index};
      end
      S_PUSH: begin
        valid_nx = 1'b1;
        insn_nx  = INSN_PUSH;
        rs1_nx   = in_data;
      end
      S_READ: begin
        valid_nx = 1'b1;
        insn_nx  = INSN_READ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      scie_valid <= 1'b0;
      scie_insn  <= '0;
      scie_rs1   <= '0;
      scie_rs2   <= '0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state      <= state_nx;
      scie_valid <= valid_nx;
      scie_insn  <= insn_nx;
      scie_rs1   <= rs1_nx;
      scie_rs2   <= rs2_nx;
      busy       <= (state_nx != S_IDLE);
      if (cfg_fire && cfg_bad) cfg_err <= 1'b1;
      if (state == S_CAPT) begin
        out_data  <= scie_rd;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SCIE_SEQ_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_samples <= '0;
      perf_stalls  <= '0;
    end else begin
      if (in_fire) perf_samples <= perf_samples + 32'd1;
      if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scie_fir_sequencer.sv
// tb/tb_scie_fir_sequencer.sv - randomized and directed bench with a transaction-level reference model
module tb_scie_fir_sequencer;
  import scie_pkg::*;

  localparam int XLEN = 32;
  localparam int TAPS = 5;
  localparam int IDXW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [IDXW-1:0] cfg_index = '0;
  logic [XLEN-1:0] cfg_coef = '0;
  logic            cfg_err;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_data;
  logic            scie_valid;
  logic [31:0]     scie_insn;
  logic [XLEN-1:0] scie_rs1;
  logic [XLEN-1:0] scie_rs2;
  logic [XLEN-1:0] scie_rd = '0;
  logic            busy;
`ifdef SCIE_SEQ_PERF_EN
  logic [31:0]     perf_samples;
  logic [31:0]     perf_stalls;
`endif

  always #5 clock = ~clock;

  scie_fir_sequencer #(.XLEN(XLEN), .TAPS(TAPS)) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_index(cfg_index),
    .cfg_coef(cfg_coef), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .scie_valid(scie_valid), .scie_insn(scie_insn), .scie_rs1(scie_rs1),
    .scie_rs2(scie_rs2), .scie_rd(scie_rd), .busy(busy)
`ifdef SCIE_SEQ_PERF_EN
    , .perf_samples(perf_samples), .perf_stalls(perf_stalls)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Filter result: sum of coef*sample over the delay line, in Q16.
  function automatic logic [31:0] fir(input logic [31:0] c [TAPS], input logic [31:0] x [TAPS]);
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 0; i < TAPS; i++) acc += {32'd0, c[i]} * {32'd0, x[i]};
    return acc[47:16];
  endfunction

  // Environment: a FIR unit that obeys the issued instruction stream.
  logic [31:0] d_coef [TAPS] = '{default: 32'd0};
  logic [31:0] d_line [TAPS] = '{default: 32'd0};
  logic [31:0] d_res = 32'd0;
  bit          saw_read = 1'b0;

  always @(negedge clock) begin
    saw_read = 1'b0;
    if (scie_valid === 1'b1) begin
      if (scie_insn == INSN_LOAD_COEF && scie_rs2 < TAPS) d_coef[scie_rs2[IDXW-1:0]] = scie_rs1;
      else if (scie_insn == INSN_PUSH) begin
        for (int i = TAPS - 1; i > 0; i--) d_line[i] = d_line[i-1];
        d_line[0] = scie_rs1;
      end else if (scie_insn == INSN_READ) begin
        saw_read = 1'b1;
        d_res = fir(d_coef, d_line);
      end
    end
  end

  always @(posedge clock) begin
    #1;
    scie_rd = saw_read ? d_res : $urandom;
  end

  // Reference model: expected instruction/result timeline derived from port handshakes.
  typedef struct { int at; logic [31:0] insn; logic [31:0] rs1; logic [31:0] rs2; } ins_t;
  typedef struct { int at; logic [31:0] data; } res_t;

  int          cyc = 0;
  int          m_cnt = 0;
  bit          m_ov = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_od = 32'd0;
  logic [31:0] m_coef [TAPS] = '{default: 32'd0};
  logic [31:0] m_line [TAPS] = '{default: 32'd0};
  logic [31:0] m_ps = 32'd0;
  logic [31:0] m_pst = 32'd0;
  ins_t        ins_q [$];
  res_t        res_q [$];
  logic [31:0] got_q [$];

  always @(negedge clock) begin
    bit cfg_fire, in_fire;
    ins_t e;
    cyc++;
    chk("busy", busy, m_cnt > 0);
    chk("cfg_ready", cfg_ready, m_cnt == 0);
    chk("in_ready", in_ready, m_cnt == 0 && !cfg_valid && !m_ov);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("cfg_err", cfg_err, m_err);
`ifdef SCIE_SEQ_PERF_EN
    chk("perf_samples", perf_samples, m_ps);
    chk("perf_stalls", perf_stalls, m_pst);
`endif
    if (ins_q.size() > 0 && ins_q[0].at == cyc) begin
      e = ins_q.pop_front();
      chk("scie_valid", scie_valid, 1);
      chk("scie_insn", scie_insn, e.insn);
      chk("scie_rs1", scie_rs1, e.rs1);
      chk("scie_rs2", scie_rs2, e.rs2);
    end else begin
      chk("scie_valid", scie_valid, 0);
      chk("scie_insn_idle", scie_insn, 0);
      chk("scie_rs1_idle", scie_rs1, 0);
      chk("scie_rs2_idle", scie_rs2, 0);
    end

    if (!reset) begin
      m_cnt = 0; m_ov = 0; m_err = 0; m_od = 0; m_ps = 0; m_pst = 0;
      ins_q.delete();
      res_q.delete();
    end else begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      cfg_fire = (m_cnt == 0) && cfg_valid;
      in_fire  = (m_cnt == 0) && !cfg_valid && !m_ov && in_valid;
      if (m_ov && !out_ready) m_pst++;
      if (res_q.size() > 0 && res_q[0].at == cyc + 1) begin
        m_ov = 1;
        m_od = res_q[0].data;
        void'(res_q.pop_front());
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (m_cnt > 0) begin
        m_cnt--;
      end else if (cfg_fire) begin
        if (cfg_index < TAPS) begin
          m_cnt = 1;
          m_coef[cfg_index] = cfg_coef;
          ins_q.push_back('{cyc + 1, INSN_LOAD_COEF, cfg_coef, {29'd0, cfg_index}});
        end else begin
          m_err = 1;
        end
      end else if (in_fire) begin
        m_cnt = 4;
        m_ps++;
        for (int i = TAPS - 1; i > 0; i--) m_line[i] = m_line[i-1];
        m_line[0] = in_data;
        ins_q.push_back('{cyc + 1, INSN_PUSH, in_data, 32'd0});
        ins_q.push_back('{cyc + 3, INSN_READ, 32'd0, 32'd0});
        res_q.push_back('{cyc + 5, fir(m_coef, m_line)});
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  time fire_t = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic hs(output bit ok);
    bit ca, ia;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      ca = cfg_valid && cfg_ready;
      ia = in_valid && in_ready;
      if (ia) fire_t = $time;
      step();
      if (ca) cfg_valid = 1'b0;
      if (ia) in_valid = 1'b0;
      if (!cfg_valid && !in_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cfg_write(input logic [IDXW-1:0] idx, input logic [31:0] coef);
    bit ok;
    cfg_valid = 1'b1; cfg_index = idx; cfg_coef = coef;
    hs(ok);
    chk("cfg_accept", ok, 1);
  endtask

  task automatic send(input logic [31:0] d);
    bit ok;
    in_valid = 1'b1; in_data = d;
    hs(ok);
    chk("in_accept", ok, 1);
  endtask

  logic [31:0] coefs   [TAPS] = '{32'd12544, 32'd56107, 32'd896, 32'd51130, 32'd9820};
  logic [31:0] samples [TAPS] = '{32'd12056, 32'd16695, 32'd37130, 32'd36128, 32'd40030};
  logic [31:0] exp_res [TAPS] = '{32'd2307, 32'd13516, 32'd21564, 32'd48337, 32'd53931};

  initial begin
    bit  ok;
    time t1;
    repeat (3) step();
    @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_scie_valid", scie_valid, 0);
    chk("reset_out_data", out_data, 0);
    step();
    reset = 1'b1;

    for (int i = 0; i < TAPS; i++) cfg_write(i[IDXW-1:0], coefs[i]);
    repeat (2) step();
    chk("cfg_err_after_load", cfg_err, 0);

    // First sample with the consumer stalled, second sample queued behind it.
    out_ready = 1'b0;
    send(samples[0]);
    in_valid = 1'b1; in_data = samples[1];
    t1 = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (out_valid) begin
        t1 = $time;
        break;
      end
    end
    chk("first_latency", (t1 - fire_t) / 10, 5);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clock);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, exp_res[0]);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_no_push", scie_valid, 0);
    end
    step();
    out_ready = 1'b1;
    hs(ok);
    chk("in_accept_after_stall", ok, 1);
    for (int i = 2; i < TAPS; i++) send(samples[i]);
    repeat (8) step();
    chk("result_count", got_q.size(), TAPS);
    for (int i = 0; i < TAPS && i < got_q.size(); i++) chk("stream_result", got_q[i], exp_res[i]);
`ifdef SCIE_SEQ_PERF_EN
    chk("perf_samples_lit", perf_samples, 5);
    chk("perf_stalls_lit", perf_stalls, 10);
`endif

    // Collision: same coefficient rewritten so the filter stays put.
    cfg_valid = 1'b1; cfg_index = 3'd2; cfg_coef = 32'd896;
    in_valid = 1'b1; in_data = 32'd5000;
    hs(ok);
    chk("collision_accept", ok, 1);
    repeat (6) step();
    cfg_write(3'd7, 32'd1234);
    @(negedge clock);
    chk("bad_index_err", cfg_err, 1);
    chk("bad_index_no_insn", scie_valid, 0);
    step();

    // Reset while in GAP: fire, PUSH, then GAP.
    send(32'd777);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_busy", busy, 0);
    chk("midreset_scie_valid", scie_valid, 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_cfg_err", cfg_err, 0);
    step();
    send(32'd4242);
    repeat (8) step();

    // Randomized traffic including out-of-range indices and backpressure.
    for (int n = 0; n < 600; n++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_index = IDXW'($urandom_range(0, 7));
      cfg_coef  = $urandom_range(0, 65535);
      in_valid  = $urandom_range(0, 1);
      in_data   = $urandom_range(0, 65535);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
